memory_responder: RTL and testbench

- Responder end of the core's memory interface: a unified instruction/data word RAM plus a small memory-mapped I/O window.
- Consumes the core's memory_address, memory_data_out and memory_write_enable; returns read data on memory_data_in with fixed one-cycle latency.
- MMIO window provides a free-running cycle counter, a GPIO output register and a byte console TX FIFO drained by a valid/ready handshake.

---
 rtl/memory_responder.sv | 135 +++++++++++++
 tb/tb_memory_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Responder side of the core memory bus: unified word RAM with one-cycle registered reads,
// plus an MMIO window holding a cycle counter, a GPIO register and a console TX byte FIFO.
module memory_responder #(
  parameter int unsigned MEM_WORDS  = 4096,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] memory_address,
  input  logic [31:0] memory_data_out,
  input  logic        memory_write_enable,
  output logic [31:0] memory_data_in,
  output logic [31:0] gpio_out,
  output logic [7:0]  console_data,
  output logic        console_valid,
  input  logic        console_ready
);

  localparam int unsigned AddrW = $clog2(MEM_WORDS);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;

  localparam logic [1:0] OffCycle   = 2'd0;
  localparam logic [1:0] OffGpio    = 2'd1;
  localparam logic [1:0] OffConsole = 2'd2;
  localparam logic [1:0] OffCtrl    = 2'd3;

  logic [31:0] mem [MEM_WORDS];

  logic [AddrW-1:0] ram_idx;
  logic             is_mmio;
  logic [1:0]       mmio_off;
  logic             unused_addr;

  assign ram_idx     = memory_address[AddrW+1:2];
  assign is_mmio     = memory_address[31];
  assign mmio_off    = memory_address[3:2];
  assign unused_addr = ^{memory_address[30:AddrW+2], memory_address[1:0]};

  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     gpio_q, gpio_d;
  logic [31:0]     cycle_q, cycle_d;
  logic            ovf_q, ovf_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [7:0]      fifo_d [FIFO_DEPTH];

  logic        mmio_wr;
  logic        push_req, fifo_push, fifo_pop, fifo_full;
  logic [31:0] status;

  always_comb begin
    mmio_wr   = memory_write_enable && is_mmio;
    fifo_pop  = (count_q != '0) && console_ready;
    fifo_full = (count_q == CntW'(FIFO_DEPTH));
    push_req  = mmio_wr && (mmio_off == OffConsole);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    fifo_push = push_req && (!fifo_full || fifo_pop);
    status    = {ovf_q, 28'b0, 3'(count_q)};

    cycle_d = cycle_q + 32'd1;
    gpio_d  = gpio_q;
    ovf_d   = ovf_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    fifo_d  = fifo_q;

    if (mmio_wr && (mmio_off == OffGpio)) gpio_d = memory_data_out;
    if (push_req && !fifo_push)           ovf_d  = 1'b1;
    if (mmio_wr && (mmio_off == OffCtrl)) ovf_d  = 1'b0;

    if (fifo_push) begin
      fifo_d[wptr_q] = memory_data_out[7:0];
      wptr_d         = wptr_q + PtrW'(1);
    end
    if (fifo_pop) rptr_d = rptr_q + PtrW'(1);

    case ({fifo_push, fifo_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    // Reads sample pre-edge state, giving read-first behaviour for RAM and GPIO.
    if (!is_mmio) begin
      rdata_d = mem[ram_idx];
    end else begin
      case (mmio_off)
        OffCycle:   rdata_d = cycle_q;
        OffGpio:    rdata_d = gpio_q;
        OffConsole: rdata_d = status;
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (memory_write_enable && !is_mmio) mem[ram_idx] <= memory_data_out;
  end

  // Storage is not reset; console_data is gated by occupancy instead.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q <= '0;
      gpio_q  <= '0;
      cycle_q <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      rdata_q <= rdata_d;
      gpio_q  <= gpio_d;
      cycle_q <= cycle_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  assign memory_data_in = rdata_q;
  assign gpio_out       = gpio_q;
  assign console_valid  = (count_q != '0);
  assign console_data   = console_valid ? fifo_q[rptr_q] : 8'h00;

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: a queue-based behavioural model predicts read data,
// console bytes, console_valid and gpio_out; independent monitors compare against the DUT.
module tb_memory_responder;

  localparam int unsigned MemWords  = 4096;
  localparam int unsigned FifoDepth = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] memory_address = '0;
  logic [31:0] memory_data_out = '0;
  logic        memory_write_enable = 1'b0;
  logic [31:0] memory_data_in;
  logic [31:0] gpio_out;
  logic [7:0]  console_data;
  logic        console_valid;
  logic        console_ready = 1'b0;

  always #5 clk = ~clk;

  memory_responder #(
    .MEM_WORDS (MemWords),
    .FIFO_DEPTH(FifoDepth),
    .INIT_FILE ("")
  ) u_dut (
    .clk                (clk),
    .resetn             (resetn),
    .memory_address     (memory_address),
    .memory_data_out    (memory_data_out),
    .memory_write_enable(memory_write_enable),
    .memory_data_in     (memory_data_in),
    .gpio_out           (gpio_out),
    .console_data       (console_data),
    .console_valid      (console_valid),
    .console_ready      (console_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard queues and reference model state.
  logic [31:0] exp_q[$];
  logic [7:0]  con_exp[$];
  logic [7:0]  mfifo[$];
  logic [31:0] mmem[int];
  logic [31:0] mcycle = '0;
  logic [31:0] mgpio = '0;
  logic        movf = 1'b0;
  logic        exp_cvalid = 1'b0;
  logic [31:0] exp_gpio = '0;
  logic [31:0] e_rd;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] a);
    int off;
    if (!a[31]) return mmem[int'((a >> 2) % MemWords)];
    off = int'((a >> 2) & 32'd3);
    case (off)
      0:       return mcycle;
      1:       return mgpio;
      2:       return (movf ? 32'h8000_0000 : 32'h0) | (32'(mfifo.size()) & 32'd7);
      default: return 32'h0;
    endcase
  endfunction

  // One bus cycle: drive inputs at the falling edge, predict, then advance the model.
  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic we, input logic rdy);
    int off;
    bit pop;
    @(negedge clk);
    memory_address      = a;
    memory_data_out     = d;
    memory_write_enable = we;
    console_ready       = rdy;
    exp_cvalid = (mfifo.size() > 0);
    exp_gpio   = mgpio;
    exp_q.push_back(model_read(a));
    pop = (mfifo.size() > 0) && rdy;
    if (pop) void'(mfifo.pop_front());
    if (we) begin
      if (!a[31]) begin
        mmem[int'((a >> 2) % MemWords)] = d;
      end else begin
        off = int'((a >> 2) & 32'd3);
        case (off)
          1: mgpio = d;
          2: begin
            if (mfifo.size() < FifoDepth) begin
              mfifo.push_back(d[7:0]);
              con_exp.push_back(d[7:0]);
            end else begin
              movf = 1'b1;
            end
          end
          3: movf = 1'b0;
          default: ;
        endcase
      end
    end
    mcycle = mcycle + 32'd1;
  endtask

  // Asserts reset mid-cycle after the last issued cycle has completed its edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    memory_write_enable = 1'b0;
    console_ready       = 1'b0;
    resetn              = 1'b0;
    exp_q.delete();
    con_exp.delete();
    mfifo.delete();
    mcycle     = '0;
    mgpio      = '0;
    movf       = 1'b0;
    exp_cvalid = 1'b0;
    exp_gpio   = '0;
    #1;
    check("rst_rdata", memory_data_in, 32'h0);
    check("rst_gpio", gpio_out, 32'h0);
    check("rst_cvalid", {31'b0, console_valid}, 32'h0);
    check("rst_cdata", {24'b0, console_data}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    resetn = 1'b1;
  endtask

  // Read-data monitor: one expected word per issued cycle, visible after that cycle's edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e_rd = exp_q.pop_front();
        check("rdata", memory_data_in, e_rd);
      end
    end
  end

  // Console/GPIO monitor, sampled mid-low-phase after inputs settle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      check("console_valid", {31'b0, console_valid}, {31'b0, exp_cvalid});
      check("gpio_out", gpio_out, exp_gpio);
      if (console_valid) begin
        if (con_exp.size() == 0) begin
          n_checks++;
          $display("FAIL console_data: got %02h want no byte (queue empty)", console_data);
        end else begin
          check("console_data", {24'b0, console_data}, {24'b0, con_exp[0]});
          if (console_ready) void'(con_exp.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] ra;
  int          idx;

  initial begin
    do_reset();

    for (int i = 0; i < 16; i++) cyc(32'(i * 4), (i == 4) ? 32'hAAAA_AAAA : $urandom, 1'b1, 1'b0);

    cyc(32'h0000_0010, 32'h1234_5678, 1'b1, 1'b0);
    cyc(32'h0000_0010, 32'h0, 1'b0, 1'b0);
    cyc(32'h0000_0013, 32'h0, 1'b0, 1'b0);

    cyc(32'h0000_0010, 32'hAAAA_AAAA, 1'b1, 1'b0);
    cyc(32'h0000_0010, 32'h5555_5555, 1'b1, 1'b0);
    cyc(32'h0000_0010, 32'h0, 1'b0, 1'b0);
    cyc(32'h0000_0010 + 4 * MemWords, 32'h0, 1'b0, 1'b0);

    cyc(32'h8000_0000, 32'h0, 1'b0, 1'b0);
    cyc(32'h8000_0000, 32'h0, 1'b0, 1'b0);
    cyc(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    cyc(32'h8000_0000, 32'h0, 1'b0, 1'b0);

    for (int b = 8'h41; b <= 8'h45; b++) cyc(32'h8000_0008, 32'(b), 1'b1, 1'b0);
    cyc(32'h8000_0008, 32'h0, 1'b0, 1'b0);
    cyc(32'h8000_000C, 32'h0, 1'b1, 1'b0);
    cyc(32'h8000_0008, 32'h0, 1'b0, 1'b0);
    cyc(32'h8000_0008, 32'h46, 1'b1, 1'b1);
    cyc(32'h8000_0008, 32'h0, 1'b0, 1'b0);
    repeat (6) cyc(32'h0, 32'h0, 1'b0, 1'b1);

    cyc(32'h8000_0004, 32'hDEAD_BEEF, 1'b1, 1'b0);
    cyc(32'h8000_0004, 32'h0, 1'b0, 1'b0);

    repeat (400) begin
      if ($urandom_range(0, 2) != 0) begin
        idx = int'($urandom_range(0, 15));
        ra  = ($urandom & 32'h7FFF_C003) | 32'(idx << 2);
      end else begin
        ra = 32'h8000_0000 | ($urandom & 32'h7FFF_FFF3) | 32'($urandom_range(0, 3) << 2);
      end
      cyc(ra, $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
    end

    // Reset during a drain: FIFO and GPIO clear, RAM survives.
    for (int b = 8'h61; b <= 8'h63; b++) cyc(32'h8000_0008, 32'(b), 1'b1, 1'b0);
    cyc(32'h8000_0004, 32'h0BAD_F00D, 1'b1, 1'b1);
    cyc(32'h0, 32'h0, 1'b0, 1'b1);
    do_reset();
    cyc(32'h8000_0000, 32'h0, 1'b0, 1'b1);
    cyc(32'h0000_0010, 32'h0, 1'b0, 1'b1);
    cyc(32'h8000_0008, 32'h0, 1'b0, 1'b1);
    repeat (3) cyc(32'h0, 32'h0, 1'b0, 1'b1);
    @(posedge clk);
    #2;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
